// File: rtl/spi_receptor.sv
// SPI responder: synchronizes SCK/SS/MOSI into CLOCK, shifts WIDTH-bit words MSB-first in all four
// CKP/CPH modes, returns the buffered TX word on MISO and pulses RX_VALID per completed word.
module spi_receptor #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             CKP,
    input  logic             CPH,
    input  logic             SCK,
    input  logic             SS,
    input  logic             MOSI,
    output logic             MISO,
    input  logic [WIDTH-1:0] TX_DATA,
    input  logic             TX_LOAD,
    output logic [WIDTH-1:0] RX_DATA,
    output logic             RX_VALID,
    output logic             BUSY
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sck_dly_q, sck_dly_d;
    logic                   ss_dly_q, ss_dly_d;
    logic [WIDTH-1:0]       tx_buf_q, tx_buf_d;
    logic [WIDTH-1:0]       shift_tx_q, shift_tx_d;
    logic [WIDTH-1:0]       shift_rx_q, shift_rx_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]       rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   busy_q, busy_d;

    logic sck_s, ss_s, mosi_s;
    logic sck_rise, sck_fall, lead_edge, trail_edge, sample_edge, out_edge;
    logic ss_fall, ss_rise;

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign ss_s   = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign sck_rise    = sck_s & ~sck_dly_q;
    assign sck_fall    = ~sck_s & sck_dly_q;
    assign lead_edge   = CKP ? sck_fall : sck_rise;
    assign trail_edge  = CKP ? sck_rise : sck_fall;
    assign sample_edge = CPH ? trail_edge : lead_edge;
    assign out_edge    = CPH ? lead_edge : trail_edge;
    assign ss_fall     = ~ss_s & ss_dly_q;
    assign ss_rise     = ss_s & ~ss_dly_q;

    // MOSI goes through the same depth as SCK so the sampled bit lines up with the detected edge.
    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], SCK};
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], SS};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
        sck_dly_d   = sck_s;
        ss_dly_d    = ss_s;
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q     <= IDLE;
            sck_sync_q  <= {SYNC_STAGES{CKP}};
            ss_sync_q   <= {SYNC_STAGES{1'b1}};
            mosi_sync_q <= '0;
            sck_dly_q   <= CKP;
            ss_dly_q    <= 1'b1;
            tx_buf_q    <= '0;
            shift_tx_q  <= '0;
            shift_rx_q  <= '0;
            bit_cnt_q   <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sck_sync_q  <= sck_sync_d;
            ss_sync_q   <= ss_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sck_dly_q   <= sck_dly_d;
            ss_dly_q    <= ss_dly_d;
            tx_buf_q    <= tx_buf_d;
            shift_tx_q  <= shift_tx_d;
            shift_rx_q  <= shift_rx_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ss_fall) state_d = SHIFT;
            SHIFT:   if (ss_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_buf_d   = TX_LOAD ? TX_DATA : tx_buf_q;
        shift_tx_d = shift_tx_q;
        shift_rx_d = shift_rx_q;
        bit_cnt_d  = bit_cnt_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        busy_d     = (state_d == SHIFT);
        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                if (ss_fall) shift_tx_d = tx_buf_q;
            end
            SHIFT: begin
                if (sample_edge) begin
                    shift_rx_d = {shift_rx_q[WIDTH-2:0], mosi_s};
                    if (bit_cnt_q == LAST_BIT) begin
                        rx_data_d  = shift_rx_d;
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                // A zero count at an out-edge marks a word boundary in both phases.
                if (out_edge) begin
                    if (bit_cnt_q == '0) shift_tx_d = tx_buf_q;
                    else                 shift_tx_d = {shift_tx_q[WIDTH-2:0], 1'b0};
                end
                if (ss_rise) bit_cnt_d = '0;
            end
            default: ;
        endcase
    end

    always_comb begin
        MISO     = (state_q == SHIFT) ? shift_tx_q[WIDTH-1] : 1'b0;
        RX_DATA  = rx_data_q;
        RX_VALID = rx_valid_q;
        BUSY     = busy_q;
    end

endmodule

// File: tb/tb_spi_receptor.sv
// Bench for spi_receptor: acts as SPI initiator, scoreboards received words against queued expectations.
module tb_spi_receptor;

    localparam int H = 6;

    logic       CLOCK = 1'b0;
    logic       RESET, CKP, CPH, SCK, SS, MOSI, TX_LOAD;
    logic [7:0] TX_DATA;
    logic       MISO, RX_VALID, BUSY;
    logic [7:0] RX_DATA;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];
    logic [7:0] model_tx;

    always #5 CLOCK = ~CLOCK;

    spi_receptor #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .CKP(CKP), .CPH(CPH), .SCK(SCK), .SS(SS), .MOSI(MOSI),
        .MISO(MISO), .TX_DATA(TX_DATA), .TX_LOAD(TX_LOAD), .RX_DATA(RX_DATA),
        .RX_VALID(RX_VALID), .BUSY(BUSY)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every RX_VALID cycle consumes one expected word.
    always @(negedge CLOCK) begin
        if (RX_VALID) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected: got %0h expected no word", RX_DATA);
            end else begin
                check("rx_data", {24'b0, RX_DATA}, {24'b0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLOCK);
    endtask

    task automatic load_tx(input logic [7:0] v);
        TX_DATA = v; TX_LOAD = 1'b1;
        tick(1);
        TX_LOAD = 1'b0;
        model_tx = v;
    endtask

    // One SS-low frame of nbits. rst_bit/load_bit >= 0 inject RESET / TX_LOAD at that bit start.
    task automatic xfer(input logic ckp, input logic cph, input int nbits, input logic [15:0] mosi,
                        input int rst_bit, input int load_bit, input logic [7:0] load_val);
        logic [15:0] cap, exp_miso;
        logic [7:0]  pre, wv;
        pre = model_tx;
        cap = '0;
        exp_miso = '0;
        for (int b = 0; b < nbits; b++) begin
            wv = (load_bit >= 0 && load_bit < 8 * (b / 8)) ? load_val : pre;
            exp_miso = {exp_miso[14:0], wv[7 - (b % 8)]};
        end
        if (rst_bit < 0)
            for (int w = 0; w < nbits / 8; w++) exp_q.push_back(mosi[(nbits - 8 - 8 * w) +: 8]);
        CKP = ckp; CPH = cph; SCK = ckp;
        tick(4);
        SS = 1'b0;
        tick(H);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_bit) begin
                RESET = 1'b1;
                tick(1);
                RESET = 1'b0;
                model_tx = '0;
                check("rst_miso", {31'b0, MISO}, 0);
                check("rst_valid", {31'b0, RX_VALID}, 0);
                check("rst_busy", {31'b0, BUSY}, 0);
                check("rst_rxdata", {24'b0, RX_DATA}, 0);
            end
            if (i == load_bit) begin
                TX_DATA = load_val; TX_LOAD = 1'b1;
                tick(1);
                TX_LOAD = 1'b0;
            end
            if (i == 1 && rst_bit < 0) check("busy_mid", {31'b0, BUSY}, 1);
            if (!cph) begin
                MOSI = mosi[nbits - 1 - i];
                tick(H);
                SCK = ~ckp;
                cap = {cap[14:0], MISO};
                tick(H);
                SCK = ckp;
            end else begin
                tick(H);
                SCK = ~ckp;
                MOSI = mosi[nbits - 1 - i];
                tick(H);
                SCK = ckp;
                cap = {cap[14:0], MISO};
            end
        end
        tick(H);
        SS = 1'b1;
        tick(8);
        if (load_bit >= 0 && rst_bit < 0) model_tx = load_val;
        if (rst_bit < 0) check("miso_word", {16'b0, cap}, {16'b0, exp_miso});
        check("busy_end", {31'b0, BUSY}, 0);
    endtask

    initial begin
        RESET = 1'b1; CKP = 1'b0; CPH = 1'b0; SCK = 1'b0; SS = 1'b1; MOSI = 1'b0;
        TX_LOAD = 1'b0; TX_DATA = '0; model_tx = '0;
        tick(3);
        RESET = 1'b0;
        tick(1);
        check("reset_miso", {31'b0, MISO}, 0);
        check("reset_rxdata", {24'b0, RX_DATA}, 0);
        check("reset_valid", {31'b0, RX_VALID}, 0);
        check("reset_busy", {31'b0, BUSY}, 0);

        load_tx(8'h3C);
        for (int m = 0; m < 4; m++) xfer(m[1], m[0], 8, 16'h00A5, -1, -1, 8'h00);
        xfer(1'b0, 1'b0, 16, 16'h1234, -1, -1, 8'h00);
        xfer(1'b0, 1'b0, 4, 16'h000A, -1, -1, 8'h00);
        xfer(1'b0, 1'b0, 8, 16'h005A, -1, -1, 8'h00);
        xfer(1'b0, 1'b1, 8, 16'h00C3, 3, -1, 8'h00);
        check("rxdata_after_rst", {24'b0, RX_DATA}, 0);
        xfer(1'b1, 1'b1, 8, 16'h005A, -1, -1, 8'h00);
        load_tx(8'h3C);
        xfer(1'b1, 1'b0, 16, 16'h3CC3, -1, 3, 8'hFF);

        for (int r = 0; r < 24; r++) begin
            logic ck, cp;
            int nb, lb;
            ck = 1'($urandom_range(0, 1));
            cp = 1'($urandom_range(0, 1));
            nb = 8 * $urandom_range(1, 2);
            lb = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : -1;
            if ($urandom_range(0, 2) == 0) load_tx(8'($urandom));
            xfer(ck, cp, nb, 16'($urandom), -1, lb, 8'($urandom));
        end

        for (int t = 0; t < 50 && exp_q.size() != 0; t++) tick(1);
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
